// File: rtl/pc_sequencer_if.sv
// Increment handshake between pc_sequencer (master, requester) and the
// incrementer (slave). inc_pulse is a one-cycle request strobe. inc_ack is an
// acknowledge pulse of arbitrary width that may be asynchronous to clk.
// adder_sum and adder_carry must be valid while inc_ack is high.
interface pc_sequencer_if;
    logic       inc_pulse;
    logic       inc_ack;
    logic [1:0] adder_sum;
    logic       adder_carry;

    modport master (
        output inc_pulse,
        input  inc_ack,
        input  adder_sum,
        input  adder_carry
    );

    modport slave (
        input  inc_pulse,
        output inc_ack,
        output adder_sum,
        output adder_carry
    );
endinterface

// File: rtl/pc_sequencer.sv
// Paper-processor control sequencer: 2-bit PC, 4-bit instruction fetch,
// INC via the incrementer handshake, plus JNO, JMP and HLT.
module pc_sequencer #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [3:0]           instr,
    pc_sequencer_if.master       inc_if,
    output logic [1:0]           pc,
    output logic [1:0]           op,
    output logic                 overflow,
    output logic                 halted,
    output logic                 error,
    output logic [7:0]           steps,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_EXEC     = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_HALT     = 3'd5
    } state_e;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_JNO = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_HLT = 2'b11;
    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    state_e     state_q, state_d;
    logic [1:0] pc_q, pc_d;
    logic [1:0] op_q, op_d;
    logic [3:0] ir_q, ir_d;
    logic       ovf_q, ovf_d;
    logic       err_q, err_d;
    logic [7:0] steps_q, steps_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ack_s1_q, ack_s1_d;
    logic       ack_s2_q, ack_s2_d;
    logic       ack_prev_q, ack_prev_d;
    logic       ack_edge;
    logic [7:0] cnt_inc;

    // ack_prev is forced high in ISSUE so an ack already high on entry
    // to WAIT_ACK must drop and rise again before it counts.
    assign ack_edge = ack_s2_q & ~ack_prev_q;
    assign cnt_inc  = cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        op_d       = op_q;
        ir_d       = ir_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        steps_d    = steps_q;
        cnt_d      = cnt_q;
        ack_s1_d   = inc_if.inc_ack;
        ack_s2_d   = ack_s1_q;
        ack_prev_d = ack_s2_q;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = instr;
                op_d    = instr[3:2];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (ir_q[3:2])
                    OP_INC: state_d = S_ISSUE;
                    OP_JNO: begin
                        pc_d    = ovf_q ? (pc_q + 2'd1) : ir_q[1:0];
                        steps_d = steps_q + 8'd1;
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_d    = ir_q[1:0];
                        steps_d = steps_q + 8'd1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        steps_d = steps_q + 8'd1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_ISSUE: begin
                cnt_d      = 8'd0;
                ack_prev_d = 1'b1;
                state_d    = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ack_edge) begin
                    pc_d    = inc_if.adder_sum;
                    ovf_d   = ovf_q | inc_if.adder_carry;
                    steps_d = steps_q + 8'd1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_L) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= 2'd0;
            op_q       <= 2'd0;
            ir_q       <= 4'd0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            steps_q    <= 8'd0;
            cnt_q      <= 8'd0;
            ack_s1_q   <= 1'b0;
            ack_s2_q   <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            op_q       <= op_d;
            ir_q       <= ir_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            steps_q    <= steps_d;
            cnt_q      <= cnt_d;
            ack_s1_q   <= ack_s1_d;
            ack_s2_q   <= ack_s2_d;
            ack_prev_q <= ack_prev_d;
        end
    end

    assign inc_if.inc_pulse = (state_q == S_ISSUE);
    assign pc        = pc_q;
    assign op        = op_q;
    assign overflow  = ovf_q;
    assign halted    = (state_q == S_HALT);
    assign error     = err_q;
    assign steps     = steps_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table of whole programs run to HALT,
// plus hand-written sequences for handshake latency, timeout, reset and wrap.
module tb_pc_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HALT = 3'd5;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       run;
  logic [3:0] instr;
  logic [1:0] pc;
  logic [1:0] op;
  logic       overflow;
  logic       halted;
  logic       error;
  logic [7:0] steps;
  logic [2:0] state_dbg;

  pc_sequencer_if bus();

  pc_sequencer #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (rst),
    .run       (run),
    .instr     (instr),
    .inc_if    (bus),
    .pc        (pc),
    .op        (op),
    .overflow  (overflow),
    .halted    (halted),
    .error     (error),
    .steps     (steps),
    .state_dbg (state_dbg)
  );

  // program memory
  logic [3:0] prog_mem [4];
  assign instr = prog_mem[pc];

  // incrementer model: acks ack_delay cycles after the pulse, holds 2 cycles
  bit         ack_en;
  bit         force_c;
  int         ack_delay;
  logic       manual_ack;
  logic       model_ack;
  logic [1:0] model_sum;
  logic       model_carry;
  int         ack_wait;
  int         ack_hold;

  assign bus.inc_ack     = model_ack | manual_ack;
  assign bus.adder_sum   = model_sum;
  assign bus.adder_carry = model_carry;

  always @(negedge clk) begin
    if (rst) begin
      model_ack   = 1'b0;
      model_sum   = 2'd0;
      model_carry = 1'b0;
      ack_wait    = 0;
      ack_hold    = 0;
    end else begin
      if (ack_hold > 0) begin
        ack_hold = ack_hold - 1;
        if (ack_hold == 0) model_ack = 1'b0;
      end
      if (ack_wait > 0) begin
        ack_wait = ack_wait - 1;
        if (ack_wait == 0) begin
          model_ack = 1'b1;
          ack_hold  = 2;
        end
      end
      if (bus.inc_pulse && ack_en) begin
        ack_wait = ack_delay;
        {model_carry, model_sum} = {1'b0, pc} + 3'd1;
        model_carry = model_carry | force_c;
      end
    end
  end

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // vector table
  typedef struct {
    logic [3:0][3:0] prog;
    bit              ack_en;
    bit              force_c;
    logic [1:0]      pc;
    logic [1:0]      op;
    logic            ovf;
    logic            err;
    logic [7:0]      steps;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [3:0] p0, input logic [3:0] p1,
                         input logic [3:0] p2, input logic [3:0] p3,
                         input bit a_en, input bit f_c,
                         input logic [1:0] e_pc, input logic [1:0] e_op,
                         input logic e_ovf, input logic e_err,
                         input logic [7:0] e_steps);
    vec_t v;
    v.prog    = {p3, p2, p1, p0};
    v.ack_en  = a_en;
    v.force_c = f_c;
    v.pc      = e_pc;
    v.op      = e_op;
    v.ovf     = e_ovf;
    v.err     = e_err;
    v.steps   = e_steps;
    vecs.push_back(v);
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    manual_ack = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [3:0] p0, input logic [3:0] p1,
                      input logic [3:0] p2, input logic [3:0] p3);
    prog_mem[0] = p0;
    prog_mem[1] = p1;
    prog_mem[2] = p2;
    prog_mem[3] = p3;
  endtask

  initial begin
    int n;
    int first_chg;
    logic [1:0] last_pc;
    logic [7:0] held_steps;
    bit seen;
    bit got;

    rst = 1'b1;
    run = 1'b0;
    manual_ack = 1'b0;
    ack_en = 1'b1;
    force_c = 1'b0;
    ack_delay = 2;
    load(4'h0, 4'h0, 4'h0, 4'h0);

    // opcodes: INC=0000, JNO t=01tt, JMP t=10tt, HLT=1100
    add_vec(4'h0, 4'h0, 4'h0, 4'hC, 1, 0, 2'd3, 2'd3, 0, 0, 8'd4);
    add_vec(4'hA, 4'hC, 4'h5, 4'hC, 1, 0, 2'd1, 2'd3, 0, 0, 8'd3);
    add_vec(4'h0, 4'h7, 4'hC, 4'hC, 1, 0, 2'd3, 2'd3, 0, 0, 8'd3);
    add_vec(4'h0, 4'h7, 4'hC, 4'hC, 1, 1, 2'd2, 2'd3, 1, 0, 8'd3);
    add_vec(4'hC, 4'h0, 4'h0, 4'h0, 1, 0, 2'd0, 2'd3, 0, 0, 8'd1);
    add_vec(4'hA, 4'hC, 4'h0, 4'hC, 0, 0, 2'd2, 2'd0, 0, 1, 8'd1);

    // reset state
    do_reset();
    check("rst_pc", pc, 0);
    check("rst_op", op, 0);
    check("rst_inc_pulse", bus.inc_pulse, 0);
    check("rst_overflow", overflow, 0);
    check("rst_halted", halted, 0);
    check("rst_error", error, 0);
    check("rst_steps", steps, 0);
    check("rst_state", state_dbg, ST_IDLE);

    // table: each program runs from reset to HALT
    for (int v = 0; v < vecs.size(); v++) begin
      do_reset();
      for (int i = 0; i < 4; i++) prog_mem[i] = vecs[v].prog[i];
      ack_en = vecs[v].ack_en;
      force_c = vecs[v].force_c;
      ack_delay = 2;
      run = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        tick();
        run = 1'b0;
        if (halted) got = 1'b1;
      end
      check($sformatf("vec%0d_halted", v), got, 1);
      check($sformatf("vec%0d_pc", v), pc, vecs[v].pc);
      check($sformatf("vec%0d_op", v), op, vecs[v].op);
      check($sformatf("vec%0d_overflow", v), overflow, vecs[v].ovf);
      check($sformatf("vec%0d_error", v), error, vecs[v].err);
      check($sformatf("vec%0d_steps", v), steps, vecs[v].steps);
      // run is ignored while halted
      held_steps = steps;
      run = 1'b1;
      repeat (3) tick();
      run = 1'b0;
      check($sformatf("vec%0d_halt_hold", v), halted, 1);
      check($sformatf("vec%0d_halt_steps", v), steps, held_steps);
    end

    // INC chain with fastest ack: pc 0->1->2->3->0, carry on the 4th
    do_reset();
    load(4'h0, 4'h0, 4'h0, 4'h0);
    ack_en = 1'b1;
    force_c = 1'b0;
    ack_delay = 1;
    exp_q.delete();
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    last_pc = 2'd0;
    first_chg = 0;
    n = 0;
    run = 1'b1;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      run = 1'b0;
      n++;
      if (pc != last_pc) begin
        if (first_chg == 0) first_chg = n;
        check("inc_pc_seq", pc, exp_q.pop_front());
        last_pc = pc;
      end
    end
    check("inc_seq_done", exp_q.size(), 0);
    // one cycle IDLE->FETCH, then the 6-cycle minimum INC
    check("inc_first_latency", first_chg, 7);
    check("inc4_pc", pc, 0);
    check("inc4_overflow", overflow, 1);
    check("inc4_steps", steps, 4);
    check("inc4_halted", halted, 0);

    // ack never comes: halt exactly 8 cycles after entering WAIT_ACK
    do_reset();
    load(4'h0, 4'hC, 4'hC, 4'hC);
    ack_en = 1'b0;
    run = 1'b1;
    for (n = 1; n <= 12; n++) begin
      tick();
      run = 1'b0;
      if (n == 11) begin
        check("tmo_halted_early", halted, 0);
        check("tmo_error_early", error, 0);
      end
    end
    check("tmo_halted", halted, 1);
    check("tmo_error", error, 1);
    check("tmo_pc", pc, 0);
    check("tmo_steps", steps, 0);

    // reset while waiting for ack, ack arriving the next cycle
    do_reset();
    load(4'h9, 4'h0, 4'hC, 4'hC);
    ack_en = 1'b0;
    run = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      tick();
      run = 1'b0;
      if (bus.inc_pulse) got = 1'b1;
    end
    check("mid_rst_pulse_seen", got, 1);
    check("mid_rst_pre_pc", pc, 1);
    check("mid_rst_pre_steps", steps, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    manual_ack = 1'b1;
    check("mid_rst_pc", pc, 0);
    check("mid_rst_op", op, 0);
    check("mid_rst_inc_pulse", bus.inc_pulse, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_halted", halted, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_steps", steps, 0);
    check("mid_rst_state", state_dbg, ST_IDLE);
    repeat (3) tick();
    manual_ack = 1'b0;
    repeat (3) tick();
    check("late_ack_pc", pc, 0);
    check("late_ack_steps", steps, 0);
    check("late_ack_state", state_dbg, ST_IDLE);

    // steps wrap: JMP-to-self for 256 instructions
    do_reset();
    load(4'h8, 4'hC, 4'hC, 4'hC);
    ack_en = 1'b1;
    run = 1'b1;
    seen = 1'b0;
    n = 0;
    got = 1'b0;
    while (n < 700 && !got) begin
      tick();
      run = 1'b0;
      n++;
      if (steps != 8'd0) seen = 1'b1;
      else if (seen) got = 1'b1;
    end
    check("wrap_seen", got, 1);
    check("wrap_cycles", n, 513);
    check("wrap_steps", steps, 0);
    check("wrap_pc", pc, 0);
    check("wrap_overflow", overflow, 0);
    check("wrap_error", error, 0);
    check("wrap_halted", halted, 0);
    check("wrap_not_halt_state", (state_dbg == ST_HALT), 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
